// File: rtl/i2c_pkg.sv
// Shared I2C definitions: writer state encoding, EEPROM device address and
// START/STOP/bit lengths in SCL quarter-periods (also used by the responder model).
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ID,
        ST_ID_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } state_t;

    localparam logic [7:0] EE_ID      = 8'hA0;
    localparam int         START_QTRS = 2;
    localparam int         STOP_QTRS  = 3;
    localparam int         BIT_QTRS   = 4;
    localparam int         SHIFT_W    = 24;

    function automatic logic is_byte_state(input state_t s);
        return (s == ST_ID) || (s == ST_REG) || (s == ST_DATA);
    endfunction

    function automatic logic is_ack_state(input state_t s);
        return (s == ST_ID_ACK) || (s == ST_REG_ACK) || (s == ST_DATA_ACK);
    endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period timebase: one-cycle tick every CLK_DIV clocks while enabled.
// Held at zero when disabled, so the first tick lands CLK_DIV cycles after enable rises.
module i2c_qtr_tick #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_byte_writer.sv
// Single-byte I2C write initiator: START, device id, register, data, STOP with ACK checks.
// Busy for 113 quarter-periods when fully ACKed; start is only accepted in IDLE, no stretching.
module i2c_byte_writer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dev_id,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    state_t               state_q, state_d;
    logic [1:0]           qidx_q, qidx_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [SHIFT_W-1:0]   shreg_q, shreg_d;
    logic                 ack_err_q, ack_err_d;
    logic                 done_q, done_d;

    logic                 qtr_tick;
    logic                 bit_end;
    logic                 bit_last;
    logic                 sda_oe;
    logic                 sda_in;

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;

    // Open-drain pad: only ever pull low, never drive high.
    assign sda    = sda_oe ? 1'b0 : 1'bz;
    assign sda_in = sda;

    i2c_qtr_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtr_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (busy),
        .tick_o (qtr_tick)
    );

    assign bit_end  = qtr_tick && (qidx_q == 2'(BIT_QTRS - 1));
    assign bit_last = bit_end && (bitcnt_q == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ack_err_q is already set by the q2 sample when the ACK slot's q3 ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_START;
            ST_START:    if (qtr_tick && (qidx_q == 2'(START_QTRS - 1))) state_d = ST_ID;
            ST_ID:       if (bit_last) state_d = ST_ID_ACK;
            ST_ID_ACK:   if (bit_end) state_d = ack_err_q ? ST_STOP : ST_REG;
            ST_REG:      if (bit_last) state_d = ST_REG_ACK;
            ST_REG_ACK:  if (bit_end) state_d = ack_err_q ? ST_STOP : ST_DATA;
            ST_DATA:     if (bit_last) state_d = ST_DATA_ACK;
            ST_DATA_ACK: if (bit_end) state_d = ST_STOP;
            ST_STOP:     if (qtr_tick && (qidx_q == 2'(STOP_QTRS - 1))) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        qidx_d    = qidx_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        ack_err_d = ack_err_q;
        done_d    = (state_q == ST_STOP) && (state_d == ST_IDLE);

        if (state_q == ST_IDLE) begin
            qidx_d   = '0;
            bitcnt_d = '0;
            if (start) begin
                shreg_d   = {dev_id, reg_addr, wdata};
                ack_err_d = 1'b0;
            end
        end else if (qtr_tick) begin
            qidx_d = (state_d != state_q) ? 2'd0 : qidx_q + 2'd1;
            if (is_byte_state(state_q) && bit_end) begin
                bitcnt_d = bitcnt_q + 3'd1;
                shreg_d  = {shreg_q[SHIFT_W-2:0], 1'b0};
            end
            if (is_ack_state(state_q) && (qidx_q == 2'd2) && sda_in) begin
                ack_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qidx_q    <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            qidx_q    <= qidx_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Bit and ACK slots: SCL low for q0/q1, high for q2/q3; data only moves in q0.
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        unique case (state_q)
            ST_START: begin
                sda_oe = 1'b1;
                scl    = (qidx_q == 2'd0);
            end
            ST_ID, ST_REG, ST_DATA: begin
                scl    = qidx_q[1];
                sda_oe = ~shreg_q[SHIFT_W-1];
            end
            ST_ID_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                scl    = qidx_q[1];
            end
            ST_STOP: begin
                scl    = (qidx_q != 2'd0);
                sda_oe = (qidx_q != 2'd2);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_writer.sv
// Bench: two writers (CLK_DIV 5 and 2) on separate pulled-up buses, each with an EEPROM responder.
// The responder decodes START/STOP/bits from the bus and ACKs only its own address.
module tb_i2c_byte_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_r;
    logic [1:0] start_r;
    logic [7:0] id_r  [2];
    logic [7:0] reg_r [2];
    logic [7:0] dat_r [2];

    wire  [1:0] busy_w, done_w, ackerr_w, scl_w;
    wire        sda0, sda1;
    logic [1:0] rsp_drv = 2'b00;

    pullup (sda0);
    pullup (sda1);
    assign sda0 = rsp_drv[0] ? 1'b0 : 1'bz;
    assign sda1 = rsp_drv[1] ? 1'b0 : 1'bz;

    wire [1:0] line_sda = {sda1, sda0};

    i2c_byte_writer #(.CLK_DIV(5)) u_dut5 (
        .clk(clk), .rst(rst_r[0]), .start(start_r[0]),
        .dev_id(id_r[0]), .reg_addr(reg_r[0]), .wdata(dat_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .ack_err(ackerr_w[0]),
        .scl(scl_w[0]), .sda(sda0)
    );

    i2c_byte_writer #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst_r[1]), .start(start_r[1]),
        .dev_id(id_r[1]), .reg_addr(reg_r[1]), .wdata(dat_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .ack_err(ackerr_w[1]),
        .scl(scl_w[1]), .sda(sda1)
    );

    // ---------------- EEPROM responder / bus monitor ----------------
    logic [1:0] ps = 2'b11;
    logic [1:0] pd = 2'b11;
    logic [1:0] in_ack = 2'b00;
    logic [1:0] addressed = 2'b00;
    logic [7:0] sr [2] = '{default: 8'h00};
    logic [7:0] cap [2][3] = '{default: '{default: 8'h00}};
    logic [7:0] last_reg [2] = '{default: 8'h00};
    logic [7:0] last_dat [2] = '{default: 8'h00};
    int bitcnt [2]     = '{default: 0};
    int nbyte [2]      = '{default: 0};
    int starts [2]     = '{default: 0};
    int stops [2]      = '{default: 0};
    int bytes_seen [2] = '{default: 0};
    int writes [2]     = '{default: 0};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            ps[g] <= scl_w[g];
            pd[g] <= line_sda[g];
            if (ps[g] && scl_w[g] && pd[g] && !line_sda[g]) begin
                starts[g]    <= starts[g] + 1;
                bitcnt[g]    <= 0;
                nbyte[g]     <= 0;
                in_ack[g]    <= 1'b0;
                addressed[g] <= 1'b0;
                rsp_drv[g]   <= 1'b0;
            end else if (ps[g] && scl_w[g] && !pd[g] && line_sda[g]) begin
                stops[g] <= stops[g] + 1;
                if (nbyte[g] == 3 && addressed[g]) begin
                    writes[g]   <= writes[g] + 1;
                    last_reg[g] <= cap[g][1];
                    last_dat[g] <= cap[g][2];
                end
            end else if (!ps[g] && scl_w[g] && !in_ack[g]) begin
                sr[g]     <= {sr[g][6:0], line_sda[g]};
                bitcnt[g] <= bitcnt[g] + 1;
            end else if (ps[g] && !scl_w[g]) begin
                if (in_ack[g]) begin
                    in_ack[g]  <= 1'b0;
                    rsp_drv[g] <= 1'b0;
                end else if (bitcnt[g] == 8) begin
                    bitcnt[g]     <= 0;
                    in_ack[g]     <= 1'b1;
                    bytes_seen[g] <= bytes_seen[g] + 1;
                    nbyte[g]      <= nbyte[g] + 1;
                    if (nbyte[g] < 3) cap[g][nbyte[g]] <= sr[g];
                    if (nbyte[g] == 0) begin
                        addressed[g] <= (sr[g] == i2c_pkg::EE_ID);
                        rsp_drv[g]   <= (sr[g] == i2c_pkg::EE_ID);
                    end else begin
                        rsp_drv[g]   <= addressed[g];
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;
    int cur_lane = 0;
    logic [7:0] exp_id, exp_reg, exp_dat;
    int snap_st, snap_sp, snap_by, snap_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (lane %0d): observed 0x%0h, expected 0x%0h", tag, cur_lane, obs, exp);
        end
    endtask

    function automatic int qdiv(input int L);
        return (L == 0) ? 5 : 2;
    endfunction

    task automatic launch(input int L, input logic [7:0] id, input logic [7:0] rg, input logic [7:0] dt);
        exp_id = id; exp_reg = rg; exp_dat = dt;
        id_r[L] = id; reg_r[L] = rg; dat_r[L] = dt;
        snap_st = starts[L]; snap_sp = stops[L];
        snap_by = bytes_seen[L]; snap_wr = writes[L];
        start_r[L] = 1'b1;
        @(negedge clk);
        start_r[L] = 1'b0;
        chk("busy_after_accept", busy_w[L], 1);
        chk("ack_err_cleared", ackerr_w[L], 0);
    endtask

    task automatic finish(input int L, input bit poke, input bit chain,
                          input logic [7:0] nid, input logic [7:0] nrg, input logic [7:0] ndt);
        int q = qdiv(L);
        bit ok = (exp_id == i2c_pkg::EE_ID);
        int cnt = 0;
        int guard = 0;
        while (done_w[L] !== 1'b1 && guard < 2000) begin
            if (busy_w[L]) cnt++;
            if (poke && guard == 37) begin
                start_r[L] = 1'b1;
                id_r[L] = 8'hA2; reg_r[L] = ~exp_reg; dat_r[L] = ~exp_dat;
            end else begin
                start_r[L] = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        start_r[L] = 1'b0;
        chk("done_seen", done_w[L], 1);
        chk("busy_cycles", cnt, (ok ? 113 : 41) * q);
        chk("busy_low_at_done", busy_w[L], 0);
        chk("ack_err", ackerr_w[L], !ok);
        chk("start_events", starts[L] - snap_st, 1);
        chk("stop_events", stops[L] - snap_sp, 1);
        chk("bytes_on_bus", bytes_seen[L] - snap_by, ok ? 3 : 1);
        chk("eeprom_writes", writes[L] - snap_wr, ok ? 1 : 0);
        if (ok) begin
            chk("captured_reg", last_reg[L], exp_reg);
            chk("captured_data", last_dat[L], exp_dat);
        end
        if (chain) begin
            launch(L, nid, nrg, ndt);
            chk("done_one_cycle", done_w[L], 0);
        end else begin
            @(negedge clk);
            chk("done_one_cycle", done_w[L], 0);
            chk("ack_err_held", ackerr_w[L], !ok);
        end
    endtask

    task automatic abort_mid(input int L);
        int q = qdiv(L);
        launch(L, 8'hA0, 8'h3C, 8'h5A);
        repeat (50 * q) @(negedge clk);
        chk("scl_low_reg_bit4", scl_w[L], 0);
        rst_r[L] = 1'b1;
        @(negedge clk);
        rst_r[L] = 1'b0;
        chk("abort_scl", scl_w[L], 1);
        chk("abort_sda", line_sda[L], 1);
        chk("abort_busy", busy_w[L], 0);
        chk("abort_done", done_w[L], 0);
        chk("abort_ack_err", ackerr_w[L], 0);
        repeat (4 * q) @(negedge clk);
        chk("abort_stays_idle", busy_w[L], 0);
        chk("abort_no_stop", stops[L] - snap_sp, 0);
    endtask

    task automatic lane_suite(input int L);
        logic [7:0] id;
        cur_lane = L;
        launch(L, 8'hA0, 8'h3C, 8'h5A); finish(L, 0, 0, 8'h00, 8'h00, 8'h00);
        launch(L, 8'hA2, 8'h11, 8'h22); finish(L, 0, 0, 8'h00, 8'h00, 8'h00);
        launch(L, 8'hA0, 8'h7E, 8'h5A); finish(L, 1, 0, 8'h00, 8'h00, 8'h00);
        launch(L, 8'hA0, 8'h01, 8'hFE); finish(L, 0, 1, 8'hA0, 8'hC3, 8'h3C);
        finish(L, 0, 0, 8'h00, 8'h00, 8'h00);
        abort_mid(L);
        launch(L, 8'hA0, 8'h3C, 8'h5A); finish(L, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) id = i2c_pkg::EE_ID;
            else id = 8'($urandom());
            launch(L, id, 8'($urandom()), 8'($urandom()));
            finish(L, 0, 0, 8'h00, 8'h00, 8'h00);
        end
    endtask

    initial begin
        rst_r = 2'b11;
        start_r = 2'b00;
        for (int i = 0; i < 2; i++) begin
            id_r[i] = 8'h00; reg_r[i] = 8'h00; dat_r[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst_r = 2'b00;
        @(negedge clk);
        for (int L = 0; L < 2; L++) begin
            cur_lane = L;
            chk("reset_busy", busy_w[L], 0);
            chk("reset_done", done_w[L], 0);
            chk("reset_ack_err", ackerr_w[L], 0);
            chk("reset_scl", scl_w[L], 1);
            chk("reset_sda", line_sda[L], 1);
        end
        lane_suite(0);
        lane_suite(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2c_byte_writer.md
# i2c_byte_writer

Single-byte I2C write initiator: on a one-cycle `start` it issues START, 7-bit device address plus W bit, register address, one data byte and STOP, checking the responder ACK after each byte. It drives the EEPROM-style responder on the shared `scl`/`sda` pair and sits between the register/config logic and the I2C bus pins. Bus timing is derived from `clk` by a fixed quarter-period divider. Clock stretching and reads are not supported.

## Interface
- `CLK_DIV`, 5: clk cycles per SCL quarter-period (q); must be ≥2; SCL period = 4·q.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request pulse; accepted only in IDLE.
- `dev_id`  input  8  address byte sent first, including the R/W bit (the EEPROM uses 8'hA0).
- `reg_addr`  input  8  register address byte.
- `wdata`  input  8  data byte.
- `busy`  output  1  high from the accept cycle + 1 until the transaction ends; reset 0.
- `done`  output  1  one-cycle pulse at the end of a transaction; reset 0.
- `ack_err`  output  1  set on any NACK; held until the next accepted `start`; reset 0.
- `scl`  output  1  push-pull SCL; reset 1.
- `sda`  inout  1  open-drain: driven 0 or released (z), never driven 1; reset released.

## Operation
- States: IDLE, START, ID, ID_ACK, REG, REG_ACK, DATA, DATA_ACK, STOP.
- IDLE: `scl`=1, `sda` released. When `start`=1, latch `dev_id`/`reg_addr`/`wdata` into a shift register, clear `ack_err`, and go to START. `start` outside IDLE is ignored. Input changes after the accept cycle have no effect.
- START (2q): q0 `sda` low with `scl` high; q1 `scl` low. Then go to ID.
- ID/REG/DATA: 8 bits, MSB first, 4q per bit:
  - q0: `scl` low; `sda` set to the bit (0 = drive, 1 = release).
  - q1: `scl` low.
  - q2, q3: `scl` high; `sda` stable.
  - A 3-bit counter ends the byte after bit 0.
- *_ACK (4q): `sda` released; same `scl` pattern. Sample `sda` on the last clk of q2. If 0 (ACK), go to the next byte state, or to STOP after DATA_ACK. If 1 (NACK), set `ack_err` and go straight to STOP.
- STOP (3q): q0 `scl` low, `sda` low; q1 `scl` high, `sda` low; q2 `scl` high, `sda` released. Then go to IDLE and pulse `done`.
- `sda` changes only while `scl` is low, except for the START and STOP edges.
- `sda` input is sampled directly; the bus is synchronous to `clk` in this system.

## Timing
- Accept cycle N: `busy`=1 from N+1.
- Full ACKed transaction: `busy` high for 113·q cycles (2q + 27·4q + 3q). `done`=1 and `busy`=0 in the same cycle, N+1+113·q. With default q: 565 busy cycles.
- NACK at ID_ACK: 41·q busy cycles. NACK at REG_ACK: 77·q.
- A `start` in the same cycle as `done` is accepted; the next START begins after ≥1 cycle of IDLE with `scl`=`sda`=1.
- `rst` mid-transaction: the next cycle is IDLE, `scl`=1, `sda` released, and all outputs take their reset values. No STOP is generated.
- Quarter counter: wraps at CLK_DIV−1 and is held at 0 in IDLE.

## Structure
- Shared package `i2c_pkg`: state encoding, a `EE_ID` = 8'hA0 constant, and the start/stop quarter counts shared with the responder model.
- One sub-module, `i2c_qtr_tick`: a counter that emits a 1-cycle tick every CLK_DIV cycles, enabled while busy. The FSM, bit counter and shifter live in the top module.

## Test plan
- Bench setup: connect the DUT to the EEPROM responder model.
- Write dev 8'hA0, reg 8'h3C, data 8'h5A with q=5: the responder captures 8'h3C/8'h5A; `busy` lasts 565 cycles; one `done` pulse; `ack_err`=0.
- Write dev 8'hA2 (no responder match): NACK at ID_ACK; `ack_err`=1; `done` after 205 cycles; no REG bits on the bus.
- Second `start` pulsed mid-transaction: ignored; a single transaction with the original data, 8'h5A.
- `rst` asserted at the 4th bit of REG: the next cycle has `scl`=1, `sda`=z, `busy`=0; a following `start` completes normally.
- Bus checker across all runs: `sda` never changes while `scl`=1 except the START fall and STOP rise; `sda` is never driven 1. Repeat with CLK_DIV=2 for minimum timing.
